data_cache: RTL

DATA_CACHE -- requirements
Module: data_cache

---
 rtl/data_cache_pkg.sv | 15 +
 rtl/cache_line_array.sv | 39 +++
 rtl/data_cache.sv | 116 +++++++++++
 3 files changed

// File: rtl/data_cache_pkg.sv
// data_cache_pkg: shared geometry, FSM states and line helpers for data_cache.
package data_cache_pkg;
  localparam int LINE_BITS = 128;
  localparam int NUM_SETS = 16;
  localparam int OFFSET_W = 2;
  localparam int INDEX_W = 4;
  localparam int TAG_W = 24;
  typedef enum logic [2:0] {IDLE, COMPARE, WRITEBACK, ALLOCATE, FILL} state_t;
  function automatic logic [LINE_BITS-1:0] put_word(input logic [LINE_BITS-1:0] line,
                                                    input logic [OFFSET_W-1:0] off,
                                                    input logic [31:0] w);
    put_word = line;
    put_word[{off, 5'd0} +: 32] = w;
  endfunction
endpackage

// File: rtl/cache_line_array.sv
// cache_line_array: tag/valid/dirty/data storage, one shared read/write index, one write port.
module cache_line_array
  import data_cache_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic [INDEX_W-1:0]   index,
  output logic                 valid,
  output logic                 dirty,
  output logic [TAG_W-1:0]     tag,
  output logic [LINE_BITS-1:0] data,
  input  logic                 we,
  input  logic                 wr_valid,
  input  logic                 wr_dirty,
  input  logic [TAG_W-1:0]     wr_tag,
  input  logic [LINE_BITS-1:0] wr_data
);
  logic [NUM_SETS-1:0]  valid_q, dirty_q;
  logic [TAG_W-1:0]     tag_q  [NUM_SETS];
  logic [LINE_BITS-1:0] data_q [NUM_SETS];
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else if (we) begin
      valid_q[index] <= wr_valid;
      dirty_q[index] <= wr_dirty;
    end
  // Tag and data are qualified by valid, so they carry no reset.
  always_ff @(posedge clk)
    if (we) begin
      tag_q[index]  <= wr_tag;
      data_q[index] <= wr_data;
    end
  assign valid = valid_q[index];
  assign dirty = dirty_q[index];
  assign tag   = tag_q[index];
  assign data  = data_q[index];
endmodule

// File: rtl/data_cache.sv
// data_cache: direct-mapped write-back write-allocate cache, 16 sets x 16-byte lines.
// Optional DATA_CACHE_STATS_EN adds hit_count/miss_count response counters.
module data_cache
  import data_cache_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 is_input_valid,
  input  logic [31:0]          addr,
  input  logic                 mem_read,
  input  logic                 mem_write,
  input  logic [31:0]          din,
  output logic                 is_ready,
  output logic                 is_output_valid,
  output logic [31:0]          dout,
  output logic                 is_hit,
  output logic                 mem_req_valid,
  input  logic                 mem_req_ready,
  output logic                 mem_req_write,
  output logic [31:0]          mem_req_addr,
  output logic [LINE_BITS-1:0] mem_req_data,
  input  logic                 mem_resp_valid,
  input  logic [LINE_BITS-1:0] mem_resp_data
`ifdef DATA_CACHE_STATS_EN
  ,
  output logic [31:0]          hit_count,
  output logic [31:0]          miss_count
`endif
);
  state_t               state, state_next;
  logic [TAG_W-1:0]     req_tag, tag, wr_tag;
  logic [INDEX_W-1:0]   req_index;
  logic [OFFSET_W-1:0]  req_offset;
  logic [31:0]          req_din;
  logic                 req_write, missed, accept, hit;
  logic                 valid, dirty, we, wr_valid, wr_dirty;
  logic [LINE_BITS-1:0] line, wr_data;
  logic                 unused_byte_bits;
  assign unused_byte_bits = ^addr[1:0];
  cache_line_array u_lines (
    .clk(clk), .reset(reset), .index(req_index),
    .valid(valid), .dirty(dirty), .tag(tag), .data(line),
    .we(we), .wr_valid(wr_valid), .wr_dirty(wr_dirty), .wr_tag(wr_tag), .wr_data(wr_data)
  );
  assign accept = is_input_valid && (mem_read || mem_write);
  assign hit    = valid && (tag == req_tag);
  // missed remembers that this transaction went to memory, so the final hit reports as a miss.
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state      <= IDLE;
      req_tag    <= '0;
      req_index  <= '0;
      req_offset <= '0;
      req_din    <= '0;
      req_write  <= 1'b0;
      missed     <= 1'b0;
    end else begin
      state <= state_next;
      if (state == IDLE && accept) begin
        req_tag    <= addr[31:8];
        req_index  <= addr[7:4];
        req_offset <= addr[3:2];
        req_din    <= din;
        req_write  <= mem_write;
        missed     <= 1'b0;
      end
      if (state == COMPARE && !hit) missed <= 1'b1;
    end
  always_comb begin
    state_next = state;
    we         = 1'b0;
    wr_valid   = 1'b1;
    wr_dirty   = 1'b0;
    wr_tag     = req_tag;
    wr_data    = line;
    case (state)
      IDLE:      state_next = accept ? COMPARE : IDLE;
      COMPARE: begin
        state_next = hit ? IDLE : (valid && dirty) ? WRITEBACK : ALLOCATE;
        we         = hit && req_write;
        wr_dirty   = 1'b1;
        wr_data    = put_word(line, req_offset, req_din);
      end
      WRITEBACK: begin
        state_next = mem_req_ready ? ALLOCATE : WRITEBACK;
        we         = mem_req_ready;
        wr_tag     = tag;
      end
      ALLOCATE:  state_next = mem_req_ready ? FILL : ALLOCATE;
      FILL: begin
        state_next = mem_resp_valid ? COMPARE : FILL;
        we         = mem_resp_valid;
        wr_data    = mem_resp_data;
      end
      default:   state_next = IDLE;
    endcase
  end
  assign is_ready        = state == IDLE;
  assign is_output_valid = state == COMPARE && hit;
  assign is_hit          = is_output_valid && !missed;
  assign dout            = (is_output_valid && !req_write) ? line[{req_offset, 5'd0} +: 32] : '0;
  assign mem_req_valid   = state == WRITEBACK || state == ALLOCATE;
  assign mem_req_write   = state == WRITEBACK;
  assign mem_req_addr    = {(state == WRITEBACK) ? tag : req_tag, req_index, 4'h0};
  assign mem_req_data    = line;
`ifdef DATA_CACHE_STATS_EN
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      hit_count  <= '0;
      miss_count <= '0;
    end else if (is_output_valid) begin
      if (missed) miss_count <= miss_count + 32'd1;
      else hit_count <= hit_count + 32'd1;
    end
`endif
endmodule
